prio_encoder_rr: RTL and testbench
==================================

# prio_encoder_rr

Parametrised, registered N-to-log2(N) encoder with selectable fixed-priority or round-robin selection and a valid/ready output handshake. It is the successor to the combinational 4-to-2 encoder: it handles any number of simultaneously active request lines, reports whether more than one line was active, and holds its result until downstream accepts it. It sits between request sources, such as interrupt or arbiter request lines, and a consumer that takes one encoded index per transfer.

## Interface
- N, default 4: number of request lines; power of two, N ≥ 2.
- W, default $clog2(N): index width; derived localparam, not overridable.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  N  request lines; bit i active-high
- mode  input  1  0 = fixed priority, highest index wins; 1 = round-robin
- out_ready  input  1  downstream accepts the current result
- out_valid  output  1  out_idx, out_onehot and out_multi are valid
- out_idx  output  W  encoded index of the selected request
- out_onehot  output  N  one-hot copy of the selected request
- out_multi  output  1  more than one req bit was set when the result was sampled
- rr_ptr  output  W  current round-robin search start; for observability

## Operation
- Handshake: hs = out_valid && out_ready.
- Load: load = !out_valid || out_ready. Inputs are sampled only on load cycles.
- During a stall (out_valid=1, out_ready=0):
  - All outputs hold.
  - req and mode are ignored; nothing is latched.
  - Requests that drop during a stall are not remembered.
- Effective pointer: eptr = (hs && mode) ? (out_idx+1) mod N : rr_ptr.
- Selection, evaluated on load:
  - mode=0: highest set bit of req.
  - mode=1: the first set bit found scanning eptr, eptr+1, … N-1, 0, … eptr-1 (wraps).
- Load with req≠0:
  - out_valid←1.
  - out_idx←selected index.
  - out_onehot←1<<out_idx.
  - out_multi←(popcount(req)>1).
- Load with req=0: out_valid, out_idx, out_onehot and out_multi all ←0.
- Pointer update:
  - On hs with mode=1: rr_ptr←(out_idx+1) mod N. Index N-1 wraps to 0.
  - hs with mode=0 leaves rr_ptr unchanged.
  - rr_ptr changes on no other event.
- Mode changes take effect at the next load. A held result is never re-evaluated.
- For a single active bit, out_idx equals the 4-to-2 OR-encoding of that bit, in both modes.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_idx=0, out_onehot=0, out_multi=0, rr_ptr=0. This holds immediately and for every cycle reset is held.
- Reset release: the first load occurs on the first rising edge with rst_n=1.
- Latency: req sampled at edge k appears on the outputs after edge k, provided edge k is a load edge. That is one cycle.
- Throughput: one result per cycle while out_ready=1.
- Back-to-back: with out_ready held at 1 and req held constant, a new result is registered every cycle. In round-robin mode, out_idx rotates through the set bits of req.
- Simultaneous hs and load in the same cycle: the new result uses eptr, which already includes the pointer advance from the accepted result.
- Reset mid-stall: the pending result is discarded and rr_ptr returns to 0.
- All outputs are registered. There is no combinational path from req, mode or out_ready to any output.

## Test plan
- Reset and idle:
  - Stimulus: assert rst_n=0 mid-run with out_valid=1.
  - Required: out_valid=0, out_idx=0, out_onehot=0, out_multi=0, rr_ptr=0, asynchronously, before the next edge.
  - Then with req=0 and rst_n=1: out_valid stays 0.
- Fixed priority, N=4, mode=0, out_ready=1:
  - req=4'b0010 → out_idx=1, out_onehot=4'b0010, out_multi=0.
  - req=4'b1011 → out_idx=3, out_multi=1.
  - rr_ptr remains 0 throughout.
- Round-robin, N=4, mode=1, req held at 4'b1011, out_ready=1:
  - out_idx sequence is 0, 1, 3, 0, 1, 3.
  - rr_ptr after each handshake is 1, 2, 0, 1, 2, 0.
- Stall:
  - Stimulus: result out_idx=2 valid, out_ready=0 for 3 cycles while req changes to 4'b0001.
  - Required: out_idx stays 2, out_valid stays 1, rr_ptr is unchanged.
  - Then out_ready=1 for one cycle: next result out_idx=0, and rr_ptr=3 (mode=1).
- Wrap and parameter sweep:
  - Set N=8, mode=1, drive rr_ptr to 7 via a handshake on index 6, then apply req=8'b1000_0001.
  - Required: out_idx=7, then after the next handshake rr_ptr=0.
  - Repeat with N=2 and N=16 against a reference model using random req, mode and out_ready.
- Mode switch:
  - Stimulus: mode 1→0 while a result is held.
  - Required: the held result is unchanged.
  - The next load with req=4'b0101 gives out_idx=2 regardless of rr_ptr.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) encoder with fixed-priority or round-robin selection
// and a valid/ready output stage that holds its result until accepted.
module prio_encoder_rr #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi,
    output logic [W-1:0] rr_ptr
);

    logic         valid_reg;
    logic [W-1:0] idx_reg;
    logic [N-1:0] onehot_reg;
    logic         multi_reg;
    logic [W-1:0] ptr_reg;

    logic         hs;
    logic         load;
    logic [W-1:0] idx_inc;
    logic [W-1:0] eptr;
    logic [N-1:0] req_rot;
    logic [W-1:0] rot_off;
    logic [W-1:0] sel_fixed;
    logic [W-1:0] sel_rr;
    logic [W-1:0] sel_next;
    logic [N-1:0] onehot_next;
    logic         multi_next;

    assign hs      = valid_reg && out_ready;
    assign load    = !valid_reg || out_ready;
    assign idx_inc = idx_reg + W'(1);
    // The accepted result's pointer advance is folded in before the new search
    assign eptr    = (hs && mode) ? idx_inc : ptr_reg;

    // N is a power of two, so W-bit addition wraps the search position mod N
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [W-1:0] pos;
        assign pos         = eptr + W'(gi);
        assign req_rot[gi] = req[pos];
    end

    always_comb begin
        rot_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) rot_off = W'(i);
        end
    end

    always_comb begin
        sel_fixed = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) sel_fixed = W'(i);
        end
    end

    assign sel_rr     = eptr + rot_off;
    assign sel_next   = mode ? sel_rr : sel_fixed;
    assign multi_next = |(req & (req - N'(1)));

    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign onehot_next[gi] = (sel_next == W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            idx_reg    <= '0;
            onehot_reg <= '0;
            multi_reg  <= 1'b0;
            ptr_reg    <= '0;
        end else begin
            if (hs && mode) ptr_reg <= idx_inc;
            if (load) begin
                if (|req) begin
                    valid_reg  <= 1'b1;
                    idx_reg    <= sel_next;
                    onehot_reg <= onehot_next;
                    multi_reg  <= multi_next;
                end else begin
                    valid_reg  <= 1'b0;
                    idx_reg    <= '0;
                    onehot_reg <= '0;
                    multi_reg  <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = valid_reg;
    assign out_idx    = idx_reg;
    assign out_onehot = onehot_reg;
    assign out_multi  = multi_reg;
    assign rr_ptr     = ptr_reg;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: scoreboarded directed vectors at N=4, a directed
// wrap case at N=8, and a reference model sweep at N=2 and N=16.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0]  req4;  logic mode4, rdy4, v4, m4;  logic [1:0] idx4, ptr4; logic [3:0]  oh4;
    logic [7:0]  req8;  logic mode8, rdy8, v8, m8;  logic [2:0] idx8, ptr8; logic [7:0]  oh8;
    logic [1:0]  req2;  logic mode2, rdy2, v2, m2;  logic [0:0] idx2, ptr2; logic [1:0]  oh2;
    logic [15:0] req16; logic mode16, rdy16, v16, m16; logic [3:0] idx16, ptr16; logic [15:0] oh16;

    prio_encoder_rr #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req4), .mode(mode4), .out_ready(rdy4),
        .out_valid(v4), .out_idx(idx4), .out_onehot(oh4), .out_multi(m4), .rr_ptr(ptr4));
    prio_encoder_rr #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
        .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .out_multi(m8), .rr_ptr(ptr8));
    prio_encoder_rr #(.N(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .mode(mode2), .out_ready(rdy2),
        .out_valid(v2), .out_idx(idx2), .out_onehot(oh2), .out_multi(m2), .rr_ptr(ptr2));
    prio_encoder_rr #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req(req16), .mode(mode16), .out_ready(rdy16),
        .out_valid(v16), .out_idx(idx16), .out_onehot(oh16), .out_multi(m16), .rr_ptr(ptr16));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] idx;
        logic [3:0] oh;
        logic       multi;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          v;
        int          idx;
        logic [15:0] oh;
        bit          multi;
        int          ptr;
    } mstate_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input int idx, input bit multi);
        exp_t e;
        e.idx   = 2'(idx);
        e.oh    = 4'(1 << idx);
        e.multi = multi;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent behavioural model used for the N=2 / N=16 sweep
    function automatic mstate_t model_next(input mstate_t s, input int n, input logic [15:0] r,
                                           input bit m, input bit rdy);
        mstate_t ns;
        bit hs, ld, found;
        int e, sel, j;
        ns = s;
        hs = s.v && rdy;
        ld = !s.v || rdy;
        if (hs && m) ns.ptr = (s.idx + 1) % n;
        if (ld) begin
            if (r == 16'h0) begin
                ns.v = 0; ns.idx = 0; ns.oh = 16'h0; ns.multi = 0;
            end else begin
                e = (hs && m) ? (s.idx + 1) % n : s.ptr;
                sel = 0;
                found = 0;
                if (!m) begin
                    for (int i = n - 1; i >= 0; i--)
                        if (r[i] && !found) begin sel = i; found = 1; end
                end else begin
                    for (int k = 0; k < n; k++) begin
                        j = (e + k) % n;
                        if (r[j] && !found) begin sel = j; found = 1; end
                    end
                end
                ns.v = 1; ns.idx = sel; ns.oh = 16'(1 << sel);
                ns.multi = ($countones(r) > 1);
            end
        end
        return ns;
    endfunction

    always @(negedge clk) begin
        if (rst_n && v4 && rdy4) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL xfer_unexpected: got idx %0d expected no result", idx4);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("xfer_idx", 32'(idx4), 32'(e.idx));
                chk("xfer_onehot", 32'(oh4), 32'(e.oh));
                chk("xfer_multi", 32'(m4), 32'(e.multi));
                $display("xfer idx=%0d onehot=%b multi=%0d", idx4, oh4, m4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    int rr_idx[6] = '{0, 1, 3, 0, 1, 3};
    int rr_ptr_exp[6] = '{1, 2, 0, 1, 2, 0};
    mstate_t s2, s16, n2, n16;

    initial begin
        rst_n = 1'b0;
        req4 = '0; mode4 = 0; rdy4 = 1;
        req8 = '0; mode8 = 0; rdy8 = 1;
        req2 = '0; mode2 = 0; rdy2 = 1;
        req16 = '0; mode16 = 0; rdy16 = 1;
        step(); step();
        chk("rst_valid", 32'(v4), 0);
        chk("rst_idx", 32'(idx4), 0);
        chk("rst_onehot", 32'(oh4), 0);
        chk("rst_multi", 32'(m4), 0);
        chk("rst_ptr", 32'(ptr4), 0);
        rst_n = 1'b1;
        step();
        chk("idle_valid", 32'(v4), 0);

        // Fixed priority, including single-bit encodings
        mode4 = 0;
        for (int b = 0; b < 4; b++) begin
            req4 = 4'(1 << b);
            push4(b, 0);
            step();
        end
        req4 = 4'b0010; push4(1, 0); step();
        req4 = 4'b1011; push4(3, 1); step();
        req4 = 4'b0000; step();
        chk("fixed_idle_valid", 32'(v4), 0);
        chk("fixed_ptr", 32'(ptr4), 0);

        // Round-robin rotation over 4'b1011
        mode4 = 1;
        req4 = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            push4(rr_idx[i], 1);
            step();
            if (i > 0) chk("rr_ptr", 32'(ptr4), 32'(rr_ptr_exp[i-1]));
        end
        req4 = 4'b0000;
        step();
        chk("rr_ptr_last", 32'(ptr4), 32'(rr_ptr_exp[5]));
        chk("rr_idle_valid", 32'(v4), 0);

        // Stall holds the result and ignores req
        req4 = 4'b0100; push4(2, 0); step();
        rdy4 = 0; req4 = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_idx", 32'(idx4), 2);
            chk("stall_valid", 32'(v4), 1);
            chk("stall_ptr", 32'(ptr4), 0);
        end
        rdy4 = 1; push4(0, 0); step();
        chk("stall_release_ptr", 32'(ptr4), 3);

        // Mode switch while a result is held
        rdy4 = 0; mode4 = 0; req4 = 4'b0101;
        step(); step();
        chk("modesw_hold_idx", 32'(idx4), 0);
        chk("modesw_hold_valid", 32'(v4), 1);
        chk("modesw_hold_ptr", 32'(ptr4), 3);
        rdy4 = 1; push4(2, 1); step();
        chk("modesw_ptr", 32'(ptr4), 3);

        // Asynchronous reset while a result is pending
        rdy4 = 0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(v4), 0);
        chk("midrst_idx", 32'(idx4), 0);
        chk("midrst_onehot", 32'(oh4), 0);
        chk("midrst_multi", 32'(m4), 0);
        chk("midrst_ptr", 32'(ptr4), 0);
        sb.delete();
        step();
        chk("midrst_hold_valid", 32'(v4), 0);
        rst_n = 1'b1; req4 = '0; rdy4 = 1;
        step();
        chk("post_rst_valid", 32'(v4), 0);
        chk("post_rst_ptr", 32'(ptr4), 0);

        // N=8 wrap from index 7 back to 0
        mode8 = 1; rdy8 = 1;
        req8 = 8'b0100_0000; step();
        chk("n8_first_idx", 32'(idx8), 6);
        req8 = 8'b1000_0001; step();
        chk("n8_wrap_idx", 32'(idx8), 7);
        chk("n8_wrap_ptr", 32'(ptr8), 7);
        chk("n8_wrap_multi", 32'(m8), 1);
        req8 = 8'b0000_0000; step();
        chk("n8_ptr_zero", 32'(ptr8), 0);
        chk("n8_idle_valid", 32'(v8), 0);

        // Model sweep at N=2 and N=16
        s2 = '{v: 0, idx: 0, oh: 16'h0, multi: 0, ptr: 0};
        s16 = s2;
        for (int c = 0; c < 300; c++) begin
            req2 = 2'($urandom); mode2 = 1'($urandom); rdy2 = ($urandom_range(0, 3) != 0);
            req16 = 16'($urandom) & 16'($urandom); mode16 = 1'($urandom);
            rdy16 = ($urandom_range(0, 3) != 0);
            n2 = model_next(s2, 2, {14'h0, req2}, mode2, rdy2);
            n16 = model_next(s16, 16, req16, mode16, rdy16);
            step();
            chk("n2_valid", 32'(v2), 32'(n2.v));
            chk("n2_idx", 32'(idx2), 32'(n2.idx));
            chk("n2_onehot", 32'(oh2), 32'(n2.oh));
            chk("n2_multi", 32'(m2), 32'(n2.multi));
            chk("n2_ptr", 32'(ptr2), 32'(n2.ptr));
            chk("n16_valid", 32'(v16), 32'(n16.v));
            chk("n16_idx", 32'(idx16), 32'(n16.idx));
            chk("n16_onehot", 32'(oh16), 32'(n16.oh));
            chk("n16_multi", 32'(m16), 32'(n16.multi));
            chk("n16_ptr", 32'(ptr16), 32'(n16.ptr));
            s2 = n2;
            s16 = n16;
        end

        chk("sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
